adder_share_arb: RTL

- Round-robin arbiter and sequencer that shares one external 32-bit carry-skip adder (carryskip32) among NUM_REQ requesters.
- Accepts one add request at a time over valid/ready and registers its operands onto the adder inputs.
- Waits ADD_CYCLES clocks for the adder to settle, then captures sum/carry into a response register tagged with the requester ID.
- Sits between client blocks and the single adder instance, which is instantiated outside this block.

---
 rtl/adder_share_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arb
// Purpose  : Round-robin arbiter/sequencer sharing one external adder among
//            NUM_REQ requesters. Registers the granted operands onto the
//            adder inputs, waits ADD_CYCLES clocks, then captures the result
//            into an ID-tagged response register.
// Revision : 1.0 - initial release
// ============================================================================
module adder_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int ID_W       = 2,
    parameter int ADD_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]       req_ci_i,
    output logic [WIDTH-1:0]         add_a_o,
    output logic [WIDTH-1:0]         add_b_o,
    output logic                     add_ci_o,
    input  logic [WIDTH-1:0]         add_s_i,
    input  logic                     add_co_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [ID_W-1:0]          resp_id_o,
    output logic [WIDTH-1:0]         resp_sum_o,
    output logic                     resp_co_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         op_count_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] add_a_q, add_b_q, resp_sum_q;
    logic             add_ci_q, resp_co_q, resp_valid_q;
    logic [ID_W-1:0]  resp_id_q;
    logic [CNT_W-1:0] op_count_q;

    logic [ID_W:0]    w_idx;
    logic [ID_W-1:0]  w_grant;
    logic             w_grant_vld;
    logic [WIDTH-1:0] w_sel_a, w_sel_b;
    logic             w_sel_ci;
    logic [ID_W-1:0]  w_rr_next;
    logic             w_accept;

    // Rotating priority search: first valid requester at or above rr_ptr.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_grant_vld && req_valid_i[w_idx[ID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx[ID_W-1:0];
            end
        end
    end

    // Operand mux for the granted requester and the next pointer value.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_ci = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_sel_a  = req_a_i[i*WIDTH +: WIDTH];
                w_sel_b  = req_b_i[i*WIDTH +: WIDTH];
                w_sel_ci = req_ci_i[i];
            end
        end
        if (w_grant == ID_W'(NUM_REQ-1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_grant + ID_W'(1);
        end
    end

    assign w_accept = (state_q == S_IDLE) && w_grant_vld;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_grant_vld)       state_d = S_EXEC;
            S_EXEC:  if (cnt_q == 4'd1)     state_d = S_RESP;
            S_RESP:  if (resp_ready_i)      state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // Output logic: ready is offered only to the current grant while idle.
    always_comb begin
        req_ready_o = '0;
        if (state_q == S_IDLE && w_grant_vld) begin
            req_ready_o[w_grant] = 1'b1;
        end
    end

    // Datapath: operand launch, settle countdown, result capture, counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_ci_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_co_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            if (w_accept) begin
                add_a_q   <= w_sel_a;
                add_b_q   <= w_sel_b;
                add_ci_q  <= w_sel_ci;
                resp_id_q <= w_grant;
                rr_ptr_q  <= w_rr_next;
                cnt_q     <= 4'(ADD_CYCLES);
            end
            if (state_q == S_EXEC) begin
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    resp_sum_q   <= add_s_i;
                    resp_co_q    <= add_co_i;
                    resp_valid_q <= 1'b1;
                end
            end
            if (state_q == S_RESP && resp_ready_i) begin
                resp_valid_q <= 1'b0;
                op_count_q   <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign add_a_o      = add_a_q;
    assign add_b_o      = add_b_q;
    assign add_ci_o     = add_ci_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_sum_o   = resp_sum_q;
    assign resp_co_o    = resp_co_q;
    assign op_count_o   = op_count_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule
`default_nettype wire
